// File: rtl/intt_pkg.sv
// Shared types and defaults for the self-sequenced INTT core.
// Holds the FSM encoding, the twiddle-mode codes and the twiddle base-index helper.
package intt_pkg;

    localparam int DEF_DATA_W   = 30;
    localparam int DEF_Q        = 998244353;
    localparam int DEF_LANES    = 2;
    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_TW_IDX_W = 12;
    localparam int DEF_BF_LAT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_STAGE = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    // Half-span of the stage plus this core's block offset within the stage.
    function automatic logic [31:0] tw_base(input logic [3:0] log_m,
                                            input int         core_index,
                                            input int         log_core_count);
        logic [31:0] h;
        logic [31:0] bc;
        h  = (log_m == 4'd0) ? 32'd0 : (32'd1 << (log_m - 4'd1));
        bc = (32'(core_index) << log_m) >> (log_core_count + 1);
        return h + bc;
    endfunction

endpackage

// File: rtl/intt_core_seq_if.sv
// RAM / twiddle-ROM / write-back bus of the INTT core.
// The core drives addresses and results (master); memories and sink sit on the slave side.
interface intt_core_seq_if
    import intt_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LANES    = DEF_LANES,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TW_IDX_W = DEF_TW_IDX_W
);
    logic                        rd_en;
    logic [ADDR_W-1:0]           rd_addr;
    logic [LANES*2*DATA_W-1:0]   ram_data;
    logic [LANES*2*DATA_W-1:0]   direct_in;
    logic [LANES*TW_IDX_W-1:0]   tw_idx;
    logic [LANES*DATA_W-1:0]     tw_data;
    logic                        out_valid;
    logic [ADDR_W-1:0]           out_addr;
    logic [LANES*DATA_W-1:0]     out_a;
    logic [LANES*DATA_W-1:0]     out_b;

    modport master (
        output rd_en, rd_addr, tw_idx, out_valid, out_addr, out_a, out_b,
        input  ram_data, direct_in, tw_data
    );

    modport slave (
        input  rd_en, rd_addr, tw_idx, out_valid, out_addr, out_a, out_b,
        output ram_data, direct_in, tw_data
    );

endinterface

// File: rtl/gs_butterfly_lane.sv
// One Gentleman-Sande butterfly: a = A+B mod Q, b = (A-B mod Q)*w mod Q.
// Exactly BF_LAT register stages from operands to results; the last stage is the output register.
module gs_butterfly_lane
    import intt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int Q      = DEF_Q,
    parameter int BF_LAT = DEF_BF_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    localparam logic [DATA_W:0]     Q_S = (DATA_W + 1)'(Q);
    localparam logic [2*DATA_W-1:0] Q_P = (2 * DATA_W)'(Q);

    function automatic logic [DATA_W-1:0] mul_mod(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        return DATA_W'(p % Q_P);
    endfunction

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] d_c;

    always_comb begin
        sum = {1'b0, a_in} + {1'b0, b_in};
        a_c = (sum >= Q_S) ? DATA_W'(sum - Q_S) : DATA_W'(sum);
        d_c = (a_in >= b_in) ? (a_in - b_in)
                             : DATA_W'({1'b0, a_in} + Q_S - {1'b0, b_in});
    end

    if (BF_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_out <= '0;
                b_out <= '0;
            end else begin
                a_out <= a_c;
                b_out <= mul_mod(d_c, w_in);
            end
        end
    end else begin : g_latn
        logic [DATA_W-1:0]   a1;
        logic [DATA_W-1:0]   d1;
        logic [DATA_W-1:0]   w1;
        logic [2*DATA_W-1:0] dly [BF_LAT-1];

        // NOTE: datapath registers are reset too, so results read as zero straight after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a1 <= '0;
                d1 <= '0;
                w1 <= '0;
                for (int i = 0; i < BF_LAT - 1; i++) dly[i] <= '0;
            end else begin
                a1     <= a_c;
                d1     <= d_c;
                w1     <= w_in;
                dly[0] <= {a1, mul_mod(d1, w1)};
                for (int i = 1; i < BF_LAT - 1; i++) dly[i] <= dly[i-1];
            end
        end

        assign a_out = dly[BF_LAT-2][2*DATA_W-1:DATA_W];
        assign b_out = dly[BF_LAT-2][DATA_W-1:0];
    end

endmodule

// File: rtl/intt_core_seq.sv
// Self-sequenced INTT stage core: walks the local RAM slice, generates per-lane twiddle
// indices, feeds LANES butterflies and emits results with an aligned write-back address.
module intt_core_seq
    import intt_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int Q              = DEF_Q,
    parameter int LANES          = DEF_LANES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TW_IDX_W       = DEF_TW_IDX_W,
    parameter int LOG_CORE_COUNT = 4,
    parameter int CORE_INDEX     = 0,
    parameter int BF_LAT         = DEF_BF_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           log_m,
    input  logic [1:0]           mode,
    input  logic [9:0]           i_in,
    input  logic                 bypass,
    intt_core_seq_if.master      bus,
    output logic                 busy,
    output logic                 done
);

    // Address-valid pipeline: index 0 is the capture cycle, the last index is the output.
    localparam int PIPE = 2 + BF_LAT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [3:0]        log_m_q;
    logic [1:0]        mode_q;
    logic [9:0]        i_in_q;
    logic              bypass_q;
    logic              rd_en_c;
    logic              inflight;

    logic [PIPE-1:0]   vld;
    logic [ADDR_W-1:0] addr_pipe [PIPE];

    logic [LANES*2*DATA_W-1:0] cap_data;
    logic [LANES*DATA_W-1:0]   cap_w;
    logic [LANES*DATA_W-1:0]   lane_a;
    logic [LANES*DATA_W-1:0]   lane_b;
    logic [LANES*TW_IDX_W-1:0] tw_idx_c;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_cnt <= '0;
            log_m_q  <= '0;
            mode_q   <= '0;
            i_in_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                log_m_q  <= log_m;
                mode_q   <= mode;
                i_in_q   <= i_in;
                bypass_q <= bypass;
            end
            if (state == ST_RUN) addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                rd_en_c = 1'b1;
                busy    = 1'b1;
                if (addr_cnt == LAST_ADDR) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!inflight) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Twiddle index is only meaningful alongside rd_en; it is forced to zero otherwise.
    always_comb begin
        logic [31:0]         base;
        logic [TW_IDX_W-1:0] idx;
        tw_idx_c = '0;
        base     = tw_base(log_m_q, CORE_INDEX, LOG_CORE_COUNT);
        for (int l = 0; l < LANES; l++) begin
            idx = '0;
            case (mode_q)
                MODE_ADDR:  idx = TW_IDX_W'(base + 32'(addr_cnt) * 32'(LANES) + 32'(l));
                MODE_STAGE: idx = TW_IDX_W'(base + 32'(i_in_q));
                MODE_CONST: idx = TW_IDX_W'(base);
                default:    idx = TW_IDX_W'(base);
            endcase
            if (rd_en_c) tw_idx_c[l*TW_IDX_W +: TW_IDX_W] = idx;
        end
    end

    // Results still ahead of the output register keep DRAIN waiting.
    assign inflight = |vld[PIPE-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < PIPE; i++) addr_pipe[i] <= '0;
            cap_data <= '0;
            cap_w    <= '0;
        end else begin
            vld          <= {vld[PIPE-2:0], rd_en_c};
            addr_pipe[0] <= addr_cnt;
            for (int i = 1; i < PIPE; i++) addr_pipe[i] <= addr_pipe[i-1];
            if (vld[0]) begin
                cap_data <= bypass_q ? bus.direct_in : bus.ram_data;
                cap_w    <= bus.tw_data;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        gs_butterfly_lane #(
            .DATA_W (DATA_W),
            .Q      (Q),
            .BF_LAT (BF_LAT)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .a_in  (cap_data[g*2*DATA_W +: DATA_W]),
            .b_in  (cap_data[g*2*DATA_W + DATA_W +: DATA_W]),
            .w_in  (cap_w[g*DATA_W +: DATA_W]),
            .a_out (lane_a[g*DATA_W +: DATA_W]),
            .b_out (lane_b[g*DATA_W +: DATA_W])
        );
    end

    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = addr_cnt;
    assign bus.tw_idx    = tw_idx_c;
    assign bus.out_valid = vld[PIPE-1];
    assign bus.out_addr  = addr_pipe[PIPE-1];
    assign bus.out_a     = lane_a;
    assign bus.out_b     = lane_b;

endmodule

// File: tb/tb_intt_core_seq.sv
// Bench for intt_core_seq: acts as RAM and twiddle ROM, scoreboards every result and
// checks sequencing, twiddle indexing, bypass, start filtering and asynchronous reset.
module tb_intt_core_seq;
    import intt_pkg::*;

    localparam int DW = 5, QT = 17, LN = 2, AW = 2, TW = 8;
    localparam int LCC = 1, CI = 1, BL = 3, NCYC = 16, NADDR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] log_m = '0;
    logic [1:0] mode = '0;
    logic [9:0] i_in = '0;
    logic       bypass = 1'b0;
    logic       busy;
    logic       done;

    intt_core_seq_if #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW), .TW_IDX_W(TW)) bus ();

    intt_core_seq #(
        .DATA_W(DW), .Q(QT), .LANES(LN), .ADDR_W(AW), .TW_IDX_W(TW),
        .LOG_CORE_COUNT(LCC), .CORE_INDEX(CI), .BF_LAT(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .log_m(log_m), .mode(mode),
        .i_in(i_in), .bypass(bypass), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [LN*DW-1:0] a;
        logic [LN*DW-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [DW-1:0] mem_a [LN][NADDR];
    logic [DW-1:0] mem_b [LN][NADDR];
    logic [DW-1:0] dir_a [LN][NADDR];
    logic [DW-1:0] dir_b [LN][NADDR];
    logic [DW-1:0] tw_rom [256];

    logic             obs_rd_en    [NCYC+1];
    logic [AW-1:0]    obs_rd_addr  [NCYC+1];
    logic [TW-1:0]    obs_tw0      [NCYC+1];
    logic [TW-1:0]    obs_tw1      [NCYC+1];
    logic             obs_valid    [NCYC+1];
    logic [AW-1:0]    obs_out_addr [NCYC+1];
    logic [LN*DW-1:0] obs_out_a    [NCYC+1];
    logic [LN*DW-1:0] obs_out_b    [NCYC+1];
    logic             obs_busy     [NCYC+1];
    logic             obs_done     [NCYC+1];
    int job_rd, job_valid, job_done;

    function automatic logic [DW-1:0] rnd_q();
        return DW'($urandom_range(QT - 1));
    endfunction

    // Reference butterfly written straight from the modular definitions.
    function automatic void model(input int av, input int bv, input int wv,
                                  output int ra, output int rb);
        ra = (av + bv) % QT;
        rb = ((((av - bv) % QT) + QT) % QT * wv) % QT;
    endfunction

    task automatic fill_random();
        for (int l = 0; l < LN; l++)
            for (int a = 0; a < NADDR; a++) begin
                mem_a[l][a] = rnd_q();
                mem_b[l][a] = rnd_q();
                dir_a[l][a] = rnd_q();
                dir_b[l][a] = rnd_q();
            end
        for (int i = 0; i < 256; i++) tw_rom[i] = rnd_q();
    endtask

    // Starts one job and services the memories for NCYC cycles; cycle k is k edges after acceptance.
    task automatic run_job(input logic [3:0] lm, input logic [1:0] md, input logic [9:0] ii,
                           input logic bp, input logic [31:0] start_mask);
        logic          pend;
        logic [AW-1:0] pend_addr;
        logic [TW-1:0] pend_tw [LN];
        logic [TW-1:0] idx;
        exp_t          e;
        int            av, bv, wv, ra, rb;
        job_rd = 0; job_valid = 0; job_done = 0;
        pend = 1'b0; pend_addr = '0;
        for (int l = 0; l < LN; l++) pend_tw[l] = '0;
        @(negedge clk);
        log_m = lm; mode = md; i_in = ii; bypass = bp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        log_m = 4'($urandom); mode = 2'($urandom); i_in = 10'($urandom); bypass = 1'($urandom);
        for (int k = 1; k <= NCYC; k++) begin
            for (int l = 0; l < LN; l++) begin
                bus.ram_data[l*2*DW +: DW]       = pend ? mem_a[l][pend_addr] : rnd_q();
                bus.ram_data[l*2*DW + DW +: DW]  = pend ? mem_b[l][pend_addr] : rnd_q();
                bus.direct_in[l*2*DW +: DW]      = pend ? dir_a[l][pend_addr] : rnd_q();
                bus.direct_in[l*2*DW + DW +: DW] = pend ? dir_b[l][pend_addr] : rnd_q();
                bus.tw_data[l*DW +: DW]          = pend ? tw_rom[pend_tw[l]] : rnd_q();
            end
            if (start_mask[k]) start = 1'b1;
            @(negedge clk);
            obs_rd_en[k]    = bus.rd_en;
            obs_rd_addr[k]  = bus.rd_addr;
            obs_tw0[k]      = bus.tw_idx[0 +: TW];
            obs_tw1[k]      = bus.tw_idx[TW +: TW];
            obs_valid[k]    = bus.out_valid;
            obs_out_addr[k] = bus.out_addr;
            obs_out_a[k]    = bus.out_a;
            obs_out_b[k]    = bus.out_b;
            obs_busy[k]     = busy;
            obs_done[k]     = done;
            if (bus.rd_en) begin
                e.addr = bus.rd_addr;
                for (int l = 0; l < LN; l++) begin
                    idx = bus.tw_idx[l*TW +: TW];
                    av  = int'(bp ? dir_a[l][e.addr] : mem_a[l][e.addr]);
                    bv  = int'(bp ? dir_b[l][e.addr] : mem_b[l][e.addr]);
                    wv  = int'(tw_rom[idx]);
                    model(av, bv, wv, ra, rb);
                    e.a[l*DW +: DW] = DW'(ra);
                    e.b[l*DW +: DW] = DW'(rb);
                    pend_tw[l] = idx;
                end
                sb.push_back(e);
                pend = 1'b1;
                pend_addr = e.addr;
                job_rd++;
            end else begin
                pend = 1'b0;
            end
            if (bus.out_valid) begin
                job_valid++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected cycle %0d: got out_addr %0d, expected no output", k, bus.out_addr);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_addr, bus.out_a, bus.out_b} !== {e.addr, e.a, e.b}) begin
                        miscompares++;
                        $display("FAIL sb_result cycle %0d: got addr %0d a %h b %h, expected addr %0d a %h b %h",
                                 k, bus.out_addr, bus.out_a, bus.out_b, e.addr, e.a, e.b);
                    end
                end
            end
            if (done) job_done++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d results missing, expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            start = 1'($urandom); log_m = 4'($urandom); mode = 2'($urandom);
            i_in = 10'($urandom); bypass = 1'($urandom);
            bus.ram_data = 20'($urandom); bus.direct_in = 20'($urandom); bus.tw_data = 10'($urandom);
            @(negedge clk);
            vectors++;
            if ({bus.rd_en, bus.rd_addr, bus.tw_idx, bus.out_valid, bus.out_addr,
                 bus.out_a, bus.out_b, busy, done} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got rd_en %b rd_addr %0d tw %h valid %b oaddr %0d a %h b %h busy %b done %b, expected all 0",
                         bus.rd_en, bus.rd_addr, bus.tw_idx, bus.out_valid, bus.out_addr,
                         bus.out_a, bus.out_b, busy, done);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [AW-1:0] xa;
        fill_random();
        run_job(4'd3, MODE_ADDR, 10'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            xa = AW'(k - 1);
            vectors++;
            if (obs_rd_en[k] !== (k >= 1 && k <= 4) ||
                (k <= 4 && (obs_rd_addr[k] !== xa || obs_tw0[k] !== TW'(6 + 2*(k-1)) ||
                            obs_tw1[k] !== TW'(7 + 2*(k-1))))) begin
                miscompares++;
                $display("FAIL seq_read cycle %0d: got rd_en %b addr %0d tw %0d/%0d, expected rd_en %b addr %0d tw %0d/%0d",
                         k, obs_rd_en[k], obs_rd_addr[k], obs_tw0[k], obs_tw1[k],
                         (k <= 4), xa, 6 + 2*(k-1), 7 + 2*(k-1));
            end
            xa = AW'(k - 6);
            vectors++;
            if (obs_valid[k] !== (k >= 6 && k <= 9) || (k >= 6 && k <= 9 && obs_out_addr[k] !== xa)) begin
                miscompares++;
                $display("FAIL seq_out cycle %0d: got valid %b addr %0d, expected valid %b addr %0d",
                         k, obs_valid[k], obs_out_addr[k], (k >= 6 && k <= 9), xa);
            end
            vectors++;
            if (obs_busy[k] !== (k <= 9) || obs_done[k] !== (k == 10)) begin
                miscompares++;
                $display("FAIL seq_ctrl cycle %0d: got busy %b done %b, expected busy %b done %b",
                         k, obs_busy[k], obs_done[k], (k <= 9), (k == 10));
            end
        end
    endtask

    task automatic test_arith();
        fill_random();
        mem_a[0][0] = 5'd5;  mem_b[0][0] = 5'd14; tw_rom[6] = 5'd3;
        mem_a[1][0] = 5'd16; mem_b[1][0] = 5'd16; tw_rom[7] = 5'd16;
        mem_a[0][1] = 5'd0;  mem_b[0][1] = 5'd0;  tw_rom[8] = 5'd5;
        run_job(4'd3, MODE_ADDR, 10'd0, 1'b0, 32'd0);
        vectors++;
        if (obs_out_a[6][0 +: DW] !== 5'd2 || obs_out_b[6][0 +: DW] !== 5'd7) begin
            miscompares++;
            $display("FAIL arith_5_14_3: got a %0d b %0d, expected a 2 b 7", obs_out_a[6][0 +: DW], obs_out_b[6][0 +: DW]);
        end
        vectors++;
        if (obs_out_a[6][DW +: DW] !== 5'd15 || obs_out_b[6][DW +: DW] !== 5'd0) begin
            miscompares++;
            $display("FAIL arith_16_16_16: got a %0d b %0d, expected a 15 b 0", obs_out_a[6][DW +: DW], obs_out_b[6][DW +: DW]);
        end
        vectors++;
        if (obs_out_a[7][0 +: DW] !== 5'd0 || obs_out_b[7][0 +: DW] !== 5'd0) begin
            miscompares++;
            $display("FAIL arith_0_0_5: got a %0d b %0d, expected a 0 b 0", obs_out_a[7][0 +: DW], obs_out_b[7][0 +: DW]);
        end
    endtask

    task automatic test_modes();
        fill_random();
        run_job(4'd3, MODE_CONST, 10'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (obs_tw0[k] !== 8'd6 || obs_tw1[k] !== 8'd6) begin
                miscompares++;
                $display("FAIL mode_const cycle %0d: got tw %0d/%0d, expected 6/6", k, obs_tw0[k], obs_tw1[k]);
            end
        end
        run_job(4'd3, MODE_STAGE, 10'd5, 1'b0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (obs_tw0[k] !== 8'd11 || obs_tw1[k] !== 8'd11) begin
                miscompares++;
                $display("FAIL mode_stage cycle %0d: got tw %0d/%0d, expected 11/11", k, obs_tw0[k], obs_tw1[k]);
            end
        end
    endtask

    task automatic test_bypass();
        fill_random();
        for (int a = 0; a < NADDR; a++) begin
            dir_a[0][a] = 5'd2;
            dir_b[0][a] = 5'd1;
        end
        tw_rom[11] = 5'd1;
        run_job(4'd3, MODE_STAGE, 10'd5, 1'b1, 32'd0);
        for (int k = 6; k <= 9; k++) begin
            vectors++;
            if (obs_out_a[k][0 +: DW] !== 5'd3 || obs_out_b[k][0 +: DW] !== 5'd1) begin
                miscompares++;
                $display("FAIL bypass cycle %0d: got a %0d b %0d, expected a 3 b 1",
                         k, obs_out_a[k][0 +: DW], obs_out_b[k][0 +: DW]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] mask;
        fill_random();
        mask = '0;
        mask[2] = 1'b1;
        mask[10] = 1'b1;
        run_job(4'd3, MODE_ADDR, 10'd0, 1'b0, mask);
        vectors++;
        if (job_rd != 4 || job_valid != 4 || job_done != 1) begin
            miscompares++;
            $display("FAIL start_ignored: got reads %0d valids %0d dones %0d, expected 4 4 1", job_rd, job_valid, job_done);
        end
    endtask

    task automatic test_reset_midjob();
        fill_random();
        @(negedge clk);
        log_m = 4'd3; mode = MODE_ADDR; i_in = '0; bypass = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== 2'd2) begin
            miscompares++;
            $display("FAIL midjob_pre: got rd_en %b addr %0d, expected 1 2", bus.rd_en, bus.rd_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0 || bus.rd_addr !== 2'd0) begin
            miscompares++;
            $display("FAIL midjob_reset: got busy %b valid %b rd_en %b addr %0d, expected 0 0 0 0",
                     busy, bus.out_valid, bus.rd_en, bus.rd_addr);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4'd3, MODE_ADDR, 10'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (obs_rd_en[k] !== 1'b1 || obs_rd_addr[k] !== AW'(k - 1)) begin
                miscompares++;
                $display("FAIL midjob_rerun cycle %0d: got rd_en %b addr %0d, expected 1 %0d",
                         k, obs_rd_en[k], obs_rd_addr[k], k - 1);
            end
        end
        vectors++;
        if (job_valid != 4 || job_done != 1 || obs_done[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL midjob_done: got valids %0d dones %0d done@10 %b, expected 4 1 1",
                     job_valid, job_done, obs_done[10]);
        end
    endtask

    initial begin
        bus.ram_data = '0;
        bus.direct_in = '0;
        bus.tw_data = '0;
        test_reset();
        test_sequence();
        test_arith();
        test_modes();
        test_bypass();
        test_start_ignored();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
